mux_nx1_scan: RTL and testbench
===============================

// Module: mux_nx1_scan
// PURPOSE
//   Parametrised, registered N:1 multiplexer for WIDTH-bit channels.
//   Manual mode: the output follows the external select.
//   Scan mode: an internal counter steps through every channel, holding each for DWELL cycles.
//   Used as the channel-selection/sampling stage ahead of downstream monitors.
//   Reports the sampled channel index, a wrap strobe and out-of-range selects.
// PARAMETERS
//   CHANNELS  8                       number of input channels (>=2)
//   WIDTH     1                       bits per channel
//   DWELL     1                       cycles each channel is held in scan mode (>=1)
//   SEL_W     $clog2(CHANNELS)        select/index width (derived, not overridden)
// PORTS
//   clk      in   1                   rising-edge clock
//   rst_n    in   1                   asynchronous active-low reset
//   i        in   CHANNELS*WIDTH      packed inputs; channel k = i[k*WIDTH +: WIDTH]
//   s        in   SEL_W               manual select
//   mode     in   1                   0 = manual, 1 = scan
//   en       in   1                   1 = sample this cycle, 0 = hold
//   y        out  WIDTH               registered selected channel
//   y_valid  out  1                   y was updated at the last edge
//   ch       out  SEL_W               index of the channel currently in y
//   wrap     out  1                   1-cycle strobe: last sample of channel CHANNELS-1 in scan mode
//   sel_err  out  1                   manual s >= CHANNELS at the last edge
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous):
//     - y, ch, y_valid, wrap and sel_err = 0
//     - scan counter sc = 0, dwell counter dc = 0
//     - state = IDLE
//   State register, updated each edge:
//     - IDLE   when en=0
//     - MANUAL when en=1, mode=0
//     - SCAN   when en=1, mode=1
//   Latency: 1 cycle; all outputs are registers.
//   IDLE:
//     - y and ch hold their last value
//     - y_valid, wrap, sel_err = 0
//     - sc and dc forced to 0
//   MANUAL:
//     - if s < CHANNELS: y <= chan[s], ch <= s, sel_err <= 0
//     - if s >= CHANNELS (only possible for non-power-of-2 CHANNELS):
//       y <= 0, ch <= s, sel_err <= 1
//     - y_valid <= 1; wrap <= 0; sc and dc forced to 0
//   SCAN (each edge):
//     - y <= chan[sc], ch <= sc, y_valid <= 1, sel_err <= 0
//     - if dc == DWELL-1:
//         dc <= 0
//         sc <= (sc == CHANNELS-1) ? 0 : sc+1
//         wrap <= (sc == CHANNELS-1)
//     - else: dc <= dc+1, wrap <= 0
//   Entering scan from IDLE or MANUAL always starts at channel 0 with a full dwell,
//   because sc and dc are held at 0 outside SCAN.
//   Mode change mid-scan takes effect at the next edge; scan progress is discarded.
//   Input changes on i are reflected at the next edge; the active channel is not latched.
//   Reset asserted mid-operation clears everything immediately.
//   The first edge after rst_n rises behaves as a fresh entry into the state selected by en/mode.
// TESTING (CHANNELS=8, WIDTH=1, DWELL=2 unless noted)
//   1. Reset:
//      rst_n=0 mid-cycle with y=1
//      -> y, ch, y_valid, wrap, sel_err = 0 immediately, before the next edge
//   2. Manual select:
//      en=1, mode=0, i=8'b11001100, s=3 -> y=1, ch=3, y_valid=1 after 1 edge
//      s=4 -> y=0, ch=4 after 1 edge
//   3. Scan:
//      en=1, mode=1, i=8'b10100101
//      -> ch = 0,0,1,1,...,7,7,0,0 on successive edges; y = i[ch]
//      -> wrap=1 only on the second ch=7 sample
//   4. Hold:
//      en=0 for 3 cycles mid-scan at ch=5
//      -> y and ch frozen, y_valid=0
//      en back to 1 -> scan restarts at ch=0
//   5. Out-of-range select (CHANNELS=6):
//      mode=0, s=6 -> y=0, sel_err=1
//      s=2 -> sel_err=0, y=i[2]
//   6. Reset mid-scan:
//      rst_n=0 at ch=5, released with en=1, mode=1
//      -> first sample ch=0, dwell of 2 edges honoured

Source files
------------

// File: rtl/mux_nx1_scan.sv
// Registered N:1 channel multiplexer with a manual select mode and an
// automatic scan mode that holds each channel for DWELL cycles.
module mux_nx1_scan #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 1,
    parameter int DWELL    = 1,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i,
    input  logic [SEL_W-1:0]          s,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    output logic [SEL_W-1:0]          ch,
    output logic                      wrap,
    output logic                      sel_err
);

    localparam int DC_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SC_LAST = SEL_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_SCAN
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               y_valid_q, y_valid_d;
    logic               wrap_q, wrap_d;
    logic               sel_err_q, sel_err_d;
    logic [SEL_W-1:0]   sc_q, sc_d;
    logic [DC_W-1:0]    dc_q, dc_d;

    logic [SEL_W-1:0]   sc_cur;
    logic [DC_W-1:0]    dc_cur;
    logic [SEL_W-1:0]   mux_sel;
    logic [WIDTH-1:0]   mux_y;
    logic               mux_hit;

    // The state being entered is chosen purely by this cycle's en/mode.
    always_comb begin
        state_d = ST_IDLE;
        if (en) begin
            state_d = mode ? ST_SCAN : ST_MANUAL;
        end
    end

    // Scan progress only survives while we stay in SCAN; any other entry starts fresh.
    assign sc_cur  = (state_q == ST_SCAN) ? sc_q : '0;
    assign dc_cur  = (state_q == ST_SCAN) ? dc_q : '0;
    assign mux_sel = (state_d == ST_SCAN) ? sc_cur : s;

    // An unmatched select (only reachable with non-power-of-2 CHANNELS) yields zero.
    always_comb begin
        mux_y   = '0;
        mux_hit = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (mux_sel == SEL_W'(k)) begin
                mux_y   = i[k*WIDTH +: WIDTH];
                mux_hit = 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        y_d       = y_q;
        ch_d      = ch_q;
        y_valid_d = 1'b0;
        wrap_d    = 1'b0;
        sel_err_d = 1'b0;
        sc_d      = '0;
        dc_d      = '0;
        case (state_d)
            ST_MANUAL: begin
                y_d       = mux_y;
                ch_d      = s;
                y_valid_d = 1'b1;
                sel_err_d = ~mux_hit;
            end
            ST_SCAN: begin
                y_d       = mux_y;
                ch_d      = sc_cur;
                y_valid_d = 1'b1;
                if (dc_cur == DC_LAST) begin
                    sc_d   = (sc_cur == SC_LAST) ? '0 : sc_cur + SEL_W'(1);
                    wrap_d = (sc_cur == SC_LAST);
                end else begin
                    sc_d = sc_cur;
                    dc_d = dc_cur + DC_W'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            y_q       <= '0;
            ch_q      <= '0;
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
            sc_q      <= '0;
            dc_q      <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            ch_q      <= ch_d;
            y_valid_q <= y_valid_d;
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
            sc_q      <= sc_d;
            dc_q      <= dc_d;
        end
    end

    assign y       = y_q;
    assign ch      = ch_q;
    assign y_valid = y_valid_q;
    assign wrap    = wrap_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: an 8-channel and a 6-channel instance,
// both with a two-cycle dwell.
module tb_mux_nx1_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;

    logic [7:0] i8;
    logic [2:0] s8;
    logic       y8, v8, w8, e8;
    logic [2:0] ch8;

    logic [5:0] i6;
    logic [2:0] s6;
    logic       y6, v6, w6, e6;
    logic [2:0] ch6;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_nx1_scan #(.CHANNELS(8), .WIDTH(1), .DWELL(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .i(i8), .s(s8), .mode(mode), .en(en),
        .y(y8), .y_valid(v8), .ch(ch8), .wrap(w8), .sel_err(e8)
    );

    mux_nx1_scan #(.CHANNELS(6), .WIDTH(1), .DWELL(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .i(i6), .s(s6), .mode(mode), .en(en),
        .y(y6), .y_valid(v6), .ch(ch6), .wrap(w6), .sel_err(e6)
    );

    typedef struct {
        logic       en;
        logic       mode;
        logic [7:0] i;
        logic [2:0] s;
        logic       y;
        logic [2:0] ch;
        logic       valid;
        logic       wrap;
        logic       err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic ey, input logic [2:0] ech,
                          input logic ev, input logic ew, input logic ee);
        check({tag, ".y"},       32'(y8),  32'(ey));
        check({tag, ".ch"},      32'(ch8), 32'(ech));
        check({tag, ".y_valid"}, 32'(v8),  32'(ev));
        check({tag, ".wrap"},    32'(w8),  32'(ew));
        check({tag, ".sel_err"}, 32'(e8),  32'(ee));
    endtask

    // Scan from a fresh entry: channel n/2 on edge n, wrap on edge wrap_at.
    task automatic run_scan8(input string tag, input int edges, input logic [7:0] iv, input int wrap_at);
        logic [2:0] ech;
        for (int n = 0; n < edges; n++) begin
            tick();
            ech = 3'((n / 2) % 8);
            check8($sformatf("%s[%0d]", tag, n), iv[ech], ech, 1'b1, n == wrap_at, 1'b0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic [2:0] ech;
        logic [5:0] iv6;

        vecs[0] = '{1'b1, 1'b0, 8'b11001100, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'b11001100, 3'd4, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'b11001100, 3'd7, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'b11001100, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'b00000001, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'b00000000, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'b00000000, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'b00100000, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; en = 1'b0; mode = 1'b0;
        i8 = '0; s8 = '0; i6 = '0; s6 = '0;
        #2;
        check8("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual select and idle hold, table driven.
        for (int k = 0; k < 8; k++) begin
            en = vecs[k].en; mode = vecs[k].mode; i8 = vecs[k].i; s8 = vecs[k].s;
            tick();
            check8($sformatf("vec%0d", k), vecs[k].y, vecs[k].ch, vecs[k].valid,
                   vecs[k].wrap, vecs[k].err);
        end

        // Asynchronous reset mid-cycle while y=1.
        #3 rst_n = 1'b0;
        #1;
        check8("async_rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        en = 1'b1; mode = 1'b1; i8 = 8'b10100101;
        @(negedge clk);
        rst_n = 1'b1;

        // Full scan cycle and back to channel 0.
        run_scan8("scan", 18, i8, 15);

        // Idle for one edge, then scan to channel 5 and hold there.
        en = 1'b0;
        tick();
        check8("idle", i8[0], 3'd0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        run_scan8("pre_hold", 11, i8, -1);
        en = 1'b0; i8 = 8'h00;
        for (int n = 0; n < 3; n++) begin
            tick();
            check8($sformatf("hold[%0d]", n), 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        end
        en = 1'b1; i8 = 8'b10100101;
        run_scan8("resume", 3, i8, -1);

        // Reset at channel 5 mid-scan, released straight into scan.
        en = 1'b0;
        tick();
        en = 1'b1;
        run_scan8("pre_rst", 11, i8, -1);
        #3 rst_n = 1'b0;
        #1;
        check8("scan_rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan8("post_rst", 4, i8, -1);

        // Mode change mid-scan discards scan progress.
        mode = 1'b0; s8 = 3'd6;
        tick();
        check8("to_manual", 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        mode = 1'b1;
        run_scan8("rescan", 2, i8, -1);

        // Six-channel instance: out-of-range manual selects.
        mode = 1'b0; i6 = 6'b111111; s6 = 3'd6;
        tick();
        check("oor6.y", 32'(y6), 32'd0);
        check("oor6.ch", 32'(ch6), 32'd6);
        check("oor6.sel_err", 32'(e6), 32'd1);
        check("oor6.y_valid", 32'(v6), 32'd1);
        s6 = 3'd7;
        tick();
        check("oor7.y", 32'(y6), 32'd0);
        check("oor7.sel_err", 32'(e6), 32'd1);
        s6 = 3'd2;
        tick();
        check("in2.y", 32'(y6), 32'd1);
        check("in2.ch", 32'(ch6), 32'd2);
        check("in2.sel_err", 32'(e6), 32'd0);

        // Six-channel scan wraps after channel 5.
        en = 1'b0;
        tick();
        check("idle6.sel_err", 32'(e6), 32'd0);
        iv6 = 6'b101100;
        i6 = iv6; en = 1'b1; mode = 1'b1;
        for (int n = 0; n < 14; n++) begin
            tick();
            ech = 3'((n / 2) % 6);
            check($sformatf("scan6[%0d].ch", n), 32'(ch6), 32'(ech));
            check($sformatf("scan6[%0d].y", n), 32'(y6), 32'(iv6[ech]));
            check($sformatf("scan6[%0d].wrap", n), 32'(w6), 32'(n == 11));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
